// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: queues branch-target updates and drains them one per allowed
// cycle, and runs a full-table invalidate sweep. Optional: `BTB_UPD_COALESCE_EN.
module btb_update_ctrl #(
  parameter int s_index    = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [31:0]        upd_target,
  output logic               upd_ready,
  input  logic               inv_req,
  output logic               inv_busy,
  input  logic               wr_allow,
  output logic               btb_we,
  output logic [s_index-1:0] btb_windex,
  output logic [31:0]        btb_wdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [s_index-1:0] LAST_IDX = '1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // Handshake: an update transfers on a cycle where upd_valid && upd_ready are both high;
  // upd_ready never depends on upd_valid.
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;

  logic [s_index-1:0] q_idx [FIFO_DEPTH];
  logic [31:0]        q_tgt [FIFO_DEPTH];
  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [s_index-1:0] sweep_idx;
  logic [s_index-1:0] upd_idx;
  logic               pop, accept, push, hit;
  logic               unused_pc;

  assign upd_idx   = upd_pc[2 +: s_index];
  assign unused_pc = ^{upd_pc[31:2+s_index], upd_pc[1:0]};
  assign pop       = (state == IDLE) && (count != '0) && wr_allow;

`ifdef BTB_UPD_COALESCE_EN
  logic [PW-1:0] hit_slot;
  logic [PW-1:0] slot_off [FIFO_DEPTH];

  // The head is excluded because it may be on the write port this very cycle.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off[i] = PW'(i) - head;
      if ((slot_off[i] != '0) && ({1'b0, slot_off[i]} < count) && (q_idx[i] == upd_idx)) begin
        hit      = 1'b1;
        hit_slot = PW'(i);
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign upd_ready = (state == IDLE) && !inv_req && ((count < FULL) || pop || hit);
  assign accept    = upd_valid && upd_ready;
  assign push      = accept && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      sweep_idx <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_idx[i] <= '0;
        q_tgt[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (inv_req) begin
            state     <= SWEEP;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            sweep_idx <= '0;
          end else begin
            if (pop) head <= head + PW'(1);
            if (push) begin
              q_idx[tail] <= upd_idx;
              q_tgt[tail] <= upd_target;
              tail        <= tail + PW'(1);
            end
`ifdef BTB_UPD_COALESCE_EN
            if (accept && hit) q_tgt[hit_slot] <= upd_target;
`endif
            count <= count + CW'(push) - CW'(pop);
          end
        end
        SWEEP: begin
          if (wr_allow) begin
            sweep_idx <= sweep_idx + s_index'(1);
            if (sweep_idx == LAST_IDX) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inv_busy   = (state == SWEEP);
  assign btb_we     = (state == SWEEP) || (count != '0);
  assign btb_windex = (state == SWEEP) ? sweep_idx : q_idx[head];
  assign btb_wdata  = (state == SWEEP) ? 32'h0 : q_tgt[head];

endmodule
